// File: rtl/boot_loader.sv
// Boot loader: copies BOOT_WORDS 32-bit words offered by the bios side into memory,
// starting at BASE_ADDR, while holding the processor. Each accepted word gets a
// one-cycle write strobe; an idle gap of TIMEOUT cycles aborts the load.
//
// Ports
//   clock        : single clock, all state changes on its rising edge
//   reset        : synchronous, active-high
//   start        : level request to begin a load (only honoured when idle)
//   word_valid   : bios presents word_data
//   word_data    : program word from bios
//   word_ready   : loader accepts a word this cycle
//   mem_address  : memory write address
//   mem_data     : memory write data
//   mem_cs       : chip select, active-low (always selected)
//   mem_we       : write strobe, one cycle per word
//   mem_oe       : output enable, high whenever the loader is not transferring
//   on_bios      : processor held for loading (low only once the load is done)
//   enable_pc    : releases the program counter
//   done         : load completed successfully
//   error        : load aborted on timeout (sticky until reset)
//   word_count   : number of words written so far
module boot_loader #(
  parameter int unsigned BOOT_WORDS = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_cs,
  output logic        mem_we,
  output logic        mem_oe,
  output logic        on_bios,
  output logic        enable_pc,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StError = 3'd4;

  localparam logic [15:0] BootWordsW = 16'(BOOT_WORDS);
  localparam logic [15:0] TimeoutW   = 16'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [15:0] count_inc;
  logic [15:0] tmo_inc;

  assign count_inc = count_q + 16'd1;
  assign tmo_inc   = tmo_q + 16'd1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          count_d = 16'd0;
          tmo_d   = 16'd0;
        end
      end
      StLoad: begin
        // A transfer wins over a timeout landing on the same edge.
        if (word_valid) begin
          state_d = StWrite;
          data_d  = word_data;
          addr_d  = BASE_ADDR + {16'd0, count_q};
          tmo_d   = 16'd0;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TimeoutW) begin
            state_d = StError;
          end
        end
      end
      StWrite: begin
        count_d = count_inc;
        state_d = (count_inc == BootWordsW) ? StDone : StLoad;
      end
      StDone:  state_d = StDone;
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= 16'd0;
      tmo_q   <= 16'd0;
      addr_q  <= BASE_ADDR;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // All outputs are decoded from registered state only.
  assign word_ready  = (state_q == StLoad);
  assign mem_we      = (state_q == StWrite);
  assign mem_oe      = (state_q != StLoad) && (state_q != StWrite);
  assign mem_cs      = 1'b0;
  assign on_bios     = (state_q != StDone);
  assign enable_pc   = (state_q == StDone);
  assign done        = (state_q == StDone);
  assign error       = (state_q == StError);
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign word_count  = count_q;

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

  localparam int unsigned BW   = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FFFE;  // forces address wrap on word 2
  localparam int unsigned TMO  = 8;

  logic        clk = 1'b0;
  logic        reset, start, word_valid;
  logic [31:0] word_data;
  logic        word_ready, mem_cs, mem_we, mem_oe, on_bios, enable_pc, done, error;
  logic [31:0] mem_address, mem_data;
  logic [15:0] word_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  boot_loader #(
    .BOOT_WORDS(BW),
    .BASE_ADDR (BASE),
    .TIMEOUT   (TMO)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .start      (start),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe),
    .on_bios    (on_bios),
    .enable_pc  (enable_pc),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  // Behavioural model: a load is "waiting" for a word, "writing" one, or has
  // finished or failed. Outputs follow directly from those facts.
  bit          m_valid = 0;
  bit          m_wait, m_writing, m_fin, m_fail;
  int          m_count, m_idle;
  logic [31:0] m_addr, m_data;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_wait = 0; m_writing = 0; m_fin = 0; m_fail = 0;
        m_count = 0; m_idle = 0; m_addr = BASE; m_data = 32'd0;
        m_valid = 1;
      end else if (m_valid) begin
        if (m_writing) begin
          m_writing = 0;
          m_count++;
          if (m_count == BW) m_fin = 1;
          else m_wait = 1;
        end else if (m_wait) begin
          if (word_valid) begin
            m_addr = BASE + 32'(m_count);
            m_data = word_data;
            m_wait = 0; m_writing = 1; m_idle = 0;
          end else begin
            m_idle++;
            if (m_idle == TMO) begin
              m_wait = 0; m_fail = 1;
            end
          end
        end else if (!m_fin && !m_fail && start) begin
          m_wait = 1; m_count = 0; m_idle = 0;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  logic [87:0] exp_v, act_v;
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        exp_v = {m_wait, m_writing, !(m_wait || m_writing), 1'b0, !m_fin, m_fin, m_fin, m_fail,
                 16'(m_count), m_addr, m_data};
        act_v = {word_ready, mem_we, mem_oe, mem_cs, on_bios, enable_pc, done, error,
                 word_count, mem_address, mem_data};
        n_checks++;
        if (act_v !== exp_v) begin
          n_errors++;
          $display("FAIL cycle_outputs @%0t: got %h expected %h", $time, act_v, exp_v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = 32'd0;
    tick(2);
    // Reset values
    chk("rst_ready", 32'(word_ready), 32'd0);
    chk("rst_addr", mem_address, 32'hFFFF_FFFE);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_oe_bios", {30'd0, mem_oe, on_bios}, 32'd3);
    chk("rst_we_cs", {30'd0, mem_we, mem_cs}, 32'd0);
    chk("rst_pc_done_err", {29'd0, enable_pc, done, error}, 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    reset = 1'b0;
    tick(1);

    // Back-to-back load, word_valid held high
    do_start();
    chk("load_ready", 32'(word_ready), 32'd1);
    word_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      word_data = 32'hA0 + 32'(i);
      tick(1);
      chk("b2b_we", 32'(mem_we), 32'd1);
      chk("b2b_ready_low", 32'(word_ready), 32'd0);
      chk("b2b_addr", mem_address, BASE + 32'(i));
      chk("b2b_data", mem_data, 32'hA0 + 32'(i));
      tick(1);
    end
    word_valid = 1'b0;
    chk("b2b_done", {29'd0, done, enable_pc, on_bios}, 32'd6);
    chk("b2b_count", 32'(word_count), 32'd4);
    // start in DONE is ignored
    start = 1'b1;
    tick(2);
    start = 1'b0;
    chk("done_sticky", 32'(done), 32'd1);
    chk("done_count", 32'(word_count), 32'd4);

    // Toggled word_valid with gaps below TIMEOUT; start pulses in LOAD ignored
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = (i == 3) ? 7 : int'($urandom_range(0, 6));
      start = 1'b1;
      tick(gap);
      start = 1'b0;
      word_valid = 1'b1;
      word_data  = 32'h1000 + 32'(i);
      tick(1);
      word_valid = 1'b0;
      chk("gap_data", mem_data, 32'h1000 + 32'(i));
      tick(1);
    end
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_no_err", 32'(error), 32'd0);

    // Timeout: error on the 8th edge after the WRITE cycle
    do_reset();
    do_start();
    word_valid = 1'b1; word_data = 32'h55;
    tick(1);
    word_valid = 1'b0;
    tick(1);
    tick(7);
    chk("tmo_not_yet", 32'(error), 32'd0);
    tick(1);
    chk("tmo_err", 32'(error), 32'd1);
    chk("tmo_count", 32'(word_count), 32'd1);
    chk("tmo_pc", 32'(enable_pc), 32'd0);
    start = 1'b1;
    tick(2);
    start = 1'b0;
    chk("tmo_sticky", {30'd0, error, mem_we}, 32'd2);

    // Transfer on the edge where the idle count would hit TIMEOUT
    do_reset();
    do_start();
    word_valid = 1'b1; word_data = 32'h77;
    tick(1);
    word_valid = 1'b0;
    tick(8);
    word_valid = 1'b1; word_data = 32'h88;
    tick(1);
    word_valid = 1'b0;
    chk("edge_we", 32'(mem_we), 32'd1);
    chk("edge_data", mem_data, 32'h88);
    chk("edge_addr", mem_address, 32'hFFFF_FFFF);
    tick(1);
    chk("edge_load", {30'd0, word_ready, error}, 32'd2);
    chk("edge_count", 32'(word_count), 32'd2);

    // Reset during WRITE of word 2, with start and word_valid also high
    do_reset();
    do_start();
    word_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      word_data = 32'hB0 + 32'(i);
      tick(2);
    end
    word_data = 32'hB2;
    tick(1);
    chk("wrap_we", 32'(mem_we), 32'd1);
    chk("wrap_addr", mem_address, 32'h0000_0000);
    reset = 1'b1; start = 1'b1;
    tick(1);
    reset = 1'b0; start = 1'b0;
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_count", 32'(word_count), 32'd0);
    chk("midrst_idle", {30'd0, word_ready, mem_oe}, 32'd1);
    do_start();
    word_data = 32'hC0;
    tick(1);
    word_valid = 1'b0;
    chk("reload_addr", mem_address, 32'hFFFF_FFFE);
    chk("reload_data", mem_data, 32'hC0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
